// File: rtl/jk_flip_flop_if.sv
// Signal bundle for a bank of WIDTH JK flip-flops: control inputs and state outputs.
// No handshake: en/j/k are sampled at every rising clk edge, and q/q_n are always valid.
interface jk_flip_flop_if #(
  parameter int WIDTH = 1
);
  logic             en;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;

  modport master (
    output en,
    output j,
    output k,
    input  q,
    input  q_n
  );

  modport slave (
    input  en,
    input  j,
    input  k,
    output q,
    output q_n
  );
endinterface

// File: rtl/jk_flip_flop.sv
// Bank of WIDTH independent positive-edge JK flip-flops with a shared enable
// and an asynchronous active-low reset that loads RST_VAL into every bit.
module jk_flip_flop #(
  parameter int   WIDTH   = 1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  jk_flip_flop_if.slave bus
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Each bit applies the JK rule on its own; en=0 freezes the whole bank.
  always_comb begin
    q_d = q_q;
    if (bus.en) begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case ({bus.j[i], bus.k[i]})
          2'b00:   q_d[i] = q_q[i];
          2'b01:   q_d[i] = 1'b0;
          2'b10:   q_d[i] = 1'b1;
          default: q_d[i] = ~q_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= {WIDTH{RST_VAL}};
    end else begin
      q_q <= q_d;
    end
  end

  // q_n is derived from the stored state, so it can never disagree with q.
  assign bus.q   = q_q;
  assign bus.q_n = ~q_q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Directed bench for jk_flip_flop: a single-bit instance and a 4-bit instance
// share clock and reset; expected values are hand-derived from the JK rule.
module tb_jk_flip_flop;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  jk_flip_flop_if #(.WIDTH(1)) bus1 ();
  jk_flip_flop_if #(.WIDTH(4)) bus4 ();

  jk_flip_flop #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  jk_flip_flop #(.WIDTH(4), .RST_VAL(1'b0)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  // clock/reset block: period 10, first rising edge at t=5
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic en, input logic j, input logic k);
    bus1.en = en;
    bus1.j  = j;
    bus1.k  = k;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive1(1'b1, 1'b0, 1'b0);
    bus4.en = 1'b0;
    bus4.j  = 4'b1111;
    bus4.k  = 4'b0000;

    // reset asserted before any edge
    #1;
    check("rst_q_before_edge",   {3'b0, bus1.q},   4'h0);
    check("rst_qn_before_edge",  {3'b0, bus1.q_n}, 4'h1);
    check("rst_q4_before_edge",  bus4.q,           4'h0);

    // reset held over edges with set applied
    drive1(1'b1, 1'b1, 1'b0);
    step();
    check("rst_hold_edge1", {3'b0, bus1.q}, 4'h0);
    step();
    check("rst_hold_edge2", {3'b0, bus1.q}, 4'h0);

    // release between edges
    rst_n = 1'b1;
    drive1(1'b1, 1'b0, 1'b0);
    #1;
    check("release_no_edge", {3'b0, bus1.q}, 4'h0);

    // basic JK sequence
    step();
    check("seq_00", {3'b0, bus1.q}, 4'h0);
    drive1(1'b1, 1'b0, 1'b1);
    step();
    check("seq_01", {3'b0, bus1.q}, 4'h0);
    drive1(1'b1, 1'b1, 1'b0);
    step();
    check("seq_10", {3'b0, bus1.q}, 4'h1);
    check("seq_10_qn", {3'b0, bus1.q_n}, 4'h0);
    drive1(1'b1, 1'b0, 1'b1);
    step();
    check("seq_01_clear", {3'b0, bus1.q}, 4'h0);
    drive1(1'b1, 1'b1, 1'b1);
    step();
    check("seq_11", {3'b0, bus1.q}, 4'h1);

    // toggle run from q=0
    drive1(1'b1, 1'b0, 1'b1);
    step();
    check("toggle_pre_clear", {3'b0, bus1.q}, 4'h0);
    drive1(1'b1, 1'b1, 1'b1);
    step();
    check("toggle1_q",  {3'b0, bus1.q},   4'h1);
    check("toggle1_qn", {3'b0, bus1.q_n}, 4'h0);
    step();
    check("toggle2_q",  {3'b0, bus1.q},   4'h0);
    check("toggle2_qn", {3'b0, bus1.q_n}, 4'h1);
    step();
    check("toggle3_q",  {3'b0, bus1.q},   4'h1);
    check("toggle3_qn", {3'b0, bus1.q_n}, 4'h0);
    step();
    check("toggle4_q",  {3'b0, bus1.q},   4'h0);
    check("toggle4_qn", {3'b0, bus1.q_n}, 4'h1);

    // enable low freezes the bank
    drive1(1'b0, 1'b1, 1'b0);
    step();
    check("en0_set_edge1", {3'b0, bus1.q}, 4'h0);
    step();
    check("en0_set_edge2", {3'b0, bus1.q}, 4'h0);
    drive1(1'b0, 1'b1, 1'b1);
    step();
    check("en0_tog_edge1", {3'b0, bus1.q}, 4'h0);
    step();
    check("en0_tog_edge2", {3'b0, bus1.q}, 4'h0);
    check("w4_en0_hold", bus4.q, 4'h0);
    drive1(1'b1, 1'b1, 1'b0);
    step();
    check("en1_resume_set", {3'b0, bus1.q}, 4'h1);

    // inputs changing between edges: no combinational path, only edge value counts
    drive1(1'b1, 1'b0, 1'b1);
    #1;
    check("no_comb_path", {3'b0, bus1.q}, 4'h1);
    drive1(1'b1, 1'b1, 1'b1);
    #1;
    drive1(1'b1, 1'b0, 1'b0);
    step();
    check("edge_sampled_hold", {3'b0, bus1.q}, 4'h1);

    // async reset mid-sequence with toggle pending
    drive1(1'b1, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_q",  {3'b0, bus1.q},   4'h0);
    check("async_rst_qn", {3'b0, bus1.q_n}, 4'h1);
    step();
    check("async_rst_over_tog", {3'b0, bus1.q}, 4'h0);
    drive1(1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b1;
    #1;
    check("release_wait_edge", {3'b0, bus1.q}, 4'h0);
    step();
    check("release_then_set", {3'b0, bus1.q}, 4'h1);

    // 4-bit bank, per-bit independence
    // bit3:10->1  bit2:01->0  bit1:11 toggle 0->1  bit0:00 hold 0
    bus4.en = 1'b1;
    bus4.j  = 4'b1010;
    bus4.k  = 4'b0110;
    step();
    check("w4_edge1", bus4.q,   4'b1010);
    check("w4_edge1_qn", bus4.q_n, 4'b0101);
    // bit1 toggles back, others repeat their set/clear/hold
    step();
    check("w4_edge2", bus4.q, 4'b1000);
    bus4.j = 4'b0101;
    bus4.k = 4'b1111;
    step();
    // bit3:01->0  bit2:11 0->1  bit1:01->0  bit0:11 0->1
    check("w4_edge3", bus4.q, 4'b0101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
